// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for the bit-serial adder controller.
interface serial_add_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry;

   // Requester side drives operands and start, observes status and result.
   modport master (
      output start, a, b,
      input  busy, done, sum, carry
   );

   // Adder side accepts operands and presents status and result.
   modport slave (
      input  start, a, b,
      output busy, done, sum, carry
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell (two half adders + OR) sequenced
// LSB first over WIDTH clocks, with a registered sum/carry and a done pulse.

// Single-bit half adder cell.
module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   // Sum and carry of two bits.
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   serial_add_ctrl_if.slave bus
);
   localparam int unsigned     CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   // Upper WIDTH-1 bits of the result shift register; the bit that would sit
   // in position 0 only matters on the final edge, where r_nxt supplies it.
   logic [WIDTH-2:0] r_sh;
   logic             c_reg;
   logic [CNT_W-1:0] cnt;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;

   logic             ha0_s;
   logic             ha0_c;
   logic             ha1_s;
   logic             ha1_c;
   logic             bit_res;
   logic             carry_nxt;
   logic [WIDTH-1:0] r_nxt;

   // Full-adder cell: operand bits first, then the stored carry.
   half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(ha0_s), .c(ha0_c));
   half_adder u_ha1 (.x(ha0_s),   .y(c_reg),   .s(ha1_s), .c(ha1_c));

   // Bit result, carry into the next bit, and the shifted result word.
   assign bit_res   = ha1_s;
   assign carry_nxt = ha0_c | ha1_c;
   assign r_nxt     = {bit_res, r_sh};

   // Control FSM, operand/result shifters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         r_sh    <= '0;
         c_reg   <= 1'b0;
         cnt     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               busy_q <= 1'b0;
               if (bus.start) begin
                  a_sh   <= bus.a;
                  b_sh   <= bus.b;
                  c_reg  <= 1'b0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               r_sh  <= r_nxt[WIDTH-1:1];
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               c_reg <= carry_nxt;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  sum_q   <= r_nxt;
                  carry_q <= carry_nxt;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Drive the result bundle from the registered outputs.
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.sum   = sum_q;
   assign bus.carry = carry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised checks of serial_add_ctrl at WIDTH 8, 2 and 16.
module tb_serial_add_ctrl;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [7:0] last_sum8;
   logic       last_c8;

   serial_add_ctrl_if #(.WIDTH(8))  if8  ();
   serial_add_ctrl_if #(.WIDTH(2))  if2  ();
   serial_add_ctrl_if #(.WIDTH(16)) if16 ();

   serial_add_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
   serial_add_ctrl #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
   serial_add_ctrl #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One 8-bit addition with cycle-by-cycle checks; optionally disturbs
   // start/a/b while the operation is running.
   task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input bit scramble);
      logic [8:0] expv;
      expv = 9'(av) + 9'(bv);
      @(negedge clk);
      if8.start = 1'b1;
      if8.a     = av;
      if8.b     = bv;
      @(negedge clk);
      if8.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_busy"},  64'(if8.busy),  64'(1));
         chk({tag, "_done0"}, 64'(if8.done),  64'(0));
         chk({tag, "_hold_s"}, 64'(if8.sum),  64'(last_sum8));
         chk({tag, "_hold_c"}, 64'(if8.carry), 64'(last_c8));
         if (scramble) begin
            if8.start = 1'b1;
            if8.a     = 8'($urandom);
            if8.b     = 8'($urandom);
         end
         @(negedge clk);
      end
      if8.start = 1'b0;
      chk({tag, "_done"},  64'(if8.done),  64'(1));
      chk({tag, "_nbusy"}, 64'(if8.busy),  64'(0));
      chk({tag, "_sum"},   64'(if8.sum),   64'(expv[7:0]));
      chk({tag, "_carry"}, 64'(if8.carry), 64'(expv[8]));
      last_sum8 = expv[7:0];
      last_c8   = expv[8];
      @(negedge clk);
      chk({tag, "_done_end"}, 64'(if8.done), 64'(0));
      chk({tag, "_idle"},     64'(if8.busy), 64'(0));
   endtask

   initial begin
      int k;
      int prev;
      int npulse;
      logic [1:0]  a2, b2;
      logic [2:0]  e2;
      logic [15:0] a16, b16;
      logic [16:0] e16;

      total = 0;
      bad   = 0;
      last_sum8 = '0;
      last_c8   = 1'b0;
      if8.start  = 1'b0; if8.a  = '0; if8.b  = '0;
      if2.start  = 1'b0; if2.a  = '0; if2.b  = '0;
      if16.start = 1'b0; if16.a = '0; if16.b = '0;

      // Asynchronous reset, checked before any clock edge.
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy",  64'(if8.busy),  64'(0));
      chk("rst_done",  64'(if8.done),  64'(0));
      chk("rst_sum",   64'(if8.sum),   64'(0));
      chk("rst_carry", 64'(if8.carry), 64'(0));
      chk("rst_sum2",  64'(if2.sum),   64'(0));
      chk("rst_sum16", 64'(if16.sum),  64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      op8("add_5a_3c", 8'h5A, 8'h3C, 1'b0);
      op8("add_ff_01", 8'hFF, 8'h01, 1'b0);
      op8("add_ff_ff", 8'hFF, 8'hFF, 1'b0);
      op8("add_00_00", 8'h00, 8'h00, 1'b0);
      op8("scramble",  8'h12, 8'h34, 1'b1);

      // Reset in the middle of an operation aborts it.
      @(negedge clk);
      if8.start = 1'b1;
      if8.a     = 8'hAA;
      if8.b     = 8'h55;
      @(negedge clk);
      if8.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_busy_pre", 64'(if8.busy), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy",  64'(if8.busy),  64'(0));
      chk("abort_done",  64'(if8.done),  64'(0));
      chk("abort_sum",   64'(if8.sum),   64'(0));
      chk("abort_carry", 64'(if8.carry), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last_sum8 = '0;
      last_c8   = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_no_done", 64'(if8.done), 64'(0));
      end

      // start held high: one result every WIDTH+2 cycles.
      if8.start = 1'b1;
      if8.a     = 8'h80;
      if8.b     = 8'h80;
      prev   = -1;
      npulse = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         chk("tp_excl", 64'(if8.busy & if8.done), 64'(0));
         if (if8.done) begin
            npulse++;
            chk("tp_sum",   64'(if8.sum),   64'(8'h00));
            chk("tp_carry", 64'(if8.carry), 64'(1));
            if (prev < 0) chk("tp_first", 64'(i), 64'(9));
            else          chk("tp_gap",   64'(i - prev), 64'(10));
            prev = i;
         end
      end
      if8.start = 1'b0;
      chk("tp_count", 64'(npulse), 64'(4));

      // Randomised operands, WIDTH=2.
      for (int n = 0; n < 20; n++) begin
         a2 = 2'($urandom);
         b2 = 2'($urandom);
         e2 = 3'(a2) + 3'(b2);
         @(negedge clk);
         if2.start = 1'b1; if2.a = a2; if2.b = b2;
         @(negedge clk);
         if2.start = 1'b0;
         k = 1;
         while (!if2.done && k < 100) begin
            @(negedge clk);
            k++;
         end
         chk("w2_lat",   64'(k),         64'(3));
         chk("w2_sum",   64'(if2.sum),   64'(e2[1:0]));
         chk("w2_carry", 64'(if2.carry), 64'(e2[2]));
         @(negedge clk);
      end

      // Randomised operands, WIDTH=16.
      for (int n = 0; n < 20; n++) begin
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         if (n == 0) begin a16 = 16'hFFFF; b16 = 16'h0001; end
         e16 = 17'(a16) + 17'(b16);
         @(negedge clk);
         if16.start = 1'b1; if16.a = a16; if16.b = b16;
         @(negedge clk);
         if16.start = 1'b0;
         k = 1;
         while (!if16.done && k < 100) begin
            @(negedge clk);
            k++;
         end
         chk("w16_lat",   64'(k),          64'(17));
         chk("w16_sum",   64'(if16.sum),   64'(e16[15:0]));
         chk("w16_carry", 64'(if16.carry), 64'(e16[16]));
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
